// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB of 2-bit saturating counters.
// EX-stage redirects (mispredict or misaligned taken target) override fetch stalls.
module pc_predict_unit #(
  parameter int               WIDTH        = 32,
  parameter int               BTB_DEPTH    = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic [WIDTH-1:0] pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic             flush,
  output logic             misalign_err
);

  localparam int               IDX     = $clog2(BTB_DEPTH);
  localparam int               TAG_W   = WIDTH - IDX - 2;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [WIDTH-1:0]     target_q [BTB_DEPTH];
  logic [1:0]           ctr_q    [BTB_DEPTH];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             mispredict, btb_we;

  // Fetch-side lookup
  assign rd_idx   = pc_q[IDX+1:2];
  assign rd_tag   = pc_q[WIDTH-1:IDX+2];
  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pc_plus4 = pc_q + PC_STEP;

  assign pc          = pc_q;
  assign pred_taken  = rd_hit & ctr_q[rd_idx][1];
  assign pred_target = rd_hit ? target_q[rd_idx] : pc_plus4;

  // Resolution side
  assign misalign_err = ex_valid & ex_taken & (ex_target[1:0] != 2'b00);
  assign mispredict   = ex_valid & ~misalign_err &
                        ((ex_taken != ex_pred_taken) |
                         (ex_taken & (ex_target != ex_pred_target)));
  assign flush        = mispredict | misalign_err;

  assign wr_idx = ex_pc[IDX+1:2];
  assign wr_tag = ex_pc[WIDTH-1:IDX+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign btb_we = ex_valid & ~misalign_err;

  // NOTE: pc_d gets a default before the priority chain so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d = pc_plus4;
    if (misalign_err)    pc_d = TRAP_VECTOR;
    else if (mispredict) pc_d = ex_taken ? ex_target : (ex_pc + PC_STEP);
    else if (stall_F)    pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (btb_we && ex_taken) valid_q[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/target/ctr have no reset; they are only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      if (ex_taken) begin
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= ex_target;
        if (!wr_hit)                       ctr_q[wr_idx] <= 2'b10;
        else if (ctr_q[wr_idx] != 2'b11)   ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
      end else if (wr_hit && (ctr_q[wr_idx] != 2'b00)) begin
        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed and randomized bench for pc_predict_unit against an arithmetic BTB/PC model.
module tb_pc_predict_unit;

  localparam int          DEPTH = 16;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall_F, ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush, misalign_err;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .WIDTH(32), .BTB_DEPTH(DEPTH), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)
  ) dut (
    .clk(clk), .rst(rst), .stall_F(stall_F), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .flush(flush), .misalign_err(misalign_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: table of branches keyed by word-address modulo DEPTH
  bit          m_valid  [DEPTH];
  int unsigned m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_ctr    [DEPTH];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_pc = RV;
  endtask

  // Entered just after a falling edge; leaves at the next falling edge.
  task automatic step(input bit st, input bit ev, input logic [31:0] epc, input bit tk,
                      input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    int unsigned idx, tg, widx, wtg;
    bit          hit, whit, e_pt, e_mis, e_misp;
    logic [31:0] e_ptgt, nxt;
    stall_F = st; ex_valid = ev; ex_pc = epc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    idx    = (m_pc / 4) % DEPTH;
    tg     = m_pc / (4 * DEPTH);
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    e_pt   = hit && (m_ctr[idx] >= 2);
    e_ptgt = hit ? m_target[idx] : m_pc + 32'd4;
    e_mis  = ev && tk && ((tgt % 4) != 0);
    e_misp = ev && !e_mis && ((tk != ptk) || (tk && (tgt != ptgt)));
    check("pc", pc, m_pc);
    check("pred_taken", 32'(pred_taken), 32'(e_pt));
    check("pred_target", pred_target, e_ptgt);
    check("misalign_err", 32'(misalign_err), 32'(e_mis));
    check("flush", 32'(flush), 32'(e_mis || e_misp));
    if (e_mis)       nxt = TV;
    else if (e_misp) nxt = tk ? tgt : epc + 32'd4;
    else if (st)     nxt = m_pc;
    else if (e_pt)   nxt = e_ptgt;
    else             nxt = m_pc + 32'd4;
    if (ev && !e_mis) begin
      widx = (epc / 4) % DEPTH;
      wtg  = epc / (4 * DEPTH);
      whit = m_valid[widx] && (m_tag[widx] == wtg);
      if (tk) begin
        m_ctr[widx]    = whit ? ((m_ctr[widx] < 3) ? m_ctr[widx] + 1 : 3) : 2;
        m_valid[widx]  = 1'b1;
        m_tag[widx]    = wtg;
        m_target[widx] = tgt;
      end else if (whit && m_ctr[widx] > 0) begin
        m_ctr[widx] = m_ctr[widx] - 1;
      end
    end
    @(posedge clk);
    m_pc = nxt;
    @(negedge clk);
  endtask

  task automatic idle(input bit st);
    step(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Not-taken resolution that was predicted taken: redirects fetch to a.
  task automatic go_to(input logic [31:0] a);
    step(1'b0, 1'b1, a - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    bit          st, ev, tk, ptk;
    logic [31:0] epc, tgt, ptgt;

    rst = 1'b0; stall_F = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    model_reset();

    @(negedge clk);
    check("reset_pc", pc, RV);
    check("reset_pred_taken", 32'(pred_taken), 32'd0);
    check("reset_pred_target", pred_target, RV + 32'd4);
    @(negedge clk);
    rst = 1'b1;

    // Free run from reset
    repeat (4) idle(1'b0);
    check("freerun_pc16", pc, 32'h10);

    // Cold taken branch, then fetch it again
    step(1'b0, 1'b1, 32'h8, 1'b1, 32'h40, 1'b0, 32'h0);
    check("cold_redirect", pc, 32'h40);
    go_to(32'h8);
    check("cold_hit_taken", 32'(pred_taken), 32'd1);
    check("cold_hit_target", pred_target, 32'h40);

    // Saturate, then decay twice
    repeat (3) step(1'b0, 1'b1, 32'h8, 1'b1, 32'h40, 1'b1, 32'h40);
    repeat (2) step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 32'h40);
    go_to(32'h8);
    check("decay_not_taken", 32'(pred_taken), 32'd0);
    idle(1'b0);
    check("decay_fallthrough", pc, 32'hC);

    // Stall holds; a redirect beats the stall
    held = m_pc;
    repeat (3) idle(1'b1);
    check("stall_hold", pc, held);
    step(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h0);
    check("redirect_over_stall", pc, 32'h24);

    // Misaligned taken target traps and leaves the BTB alone
    step(1'b0, 1'b1, 32'h8, 1'b1, 32'h42, 1'b1, 32'h40);
    check("misalign_trap", pc, TV);
    go_to(32'h8);
    check("misalign_btb_taken", 32'(pred_taken), 32'd0);
    check("misalign_btb_target", pred_target, 32'h40);

    // PC wrap
    go_to(32'hFFFF_FFFC);
    idle(1'b0);
    check("wrap_pc", pc, 32'h0);

    // Aliasing: 0x10 and 0x50 share an index
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h50, 1'b1, 32'hC0, 1'b0, 32'h0);
    go_to(32'h10);
    check("alias_first_miss", 32'(pred_taken), 32'd0);
    check("alias_first_target", pred_target, 32'h14);
    go_to(32'h50);
    check("alias_second_hit", pred_target, 32'hC0);
    // Same-cycle read and update of the entry being fetched
    step(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 32'hC0);

    // Reset during a pending redirect
    ex_valid = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h200;
    ex_pred_taken = 1'b0; stall_F = 1'b0;
    #2 rst = 1'b0;
    #1 check("midreset_pc_async", pc, RV);
    @(posedge clk);
    #1 check("midreset_discard", pc, RV);
    check("midreset_pred_taken", 32'(pred_taken), 32'd0);
    model_reset();
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      ev  = ($urandom_range(0, 1) == 1);
      epc = 32'($urandom_range(0, 63)) * 32'd4;
      if ($urandom_range(0, 3) == 0) epc = epc + 32'h1000;
      tk  = ($urandom_range(0, 1) == 1);
      tgt = 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 7) == 0) tgt = tgt + 32'($urandom_range(1, 3));
      ptk = ($urandom_range(0, 1) == 1);
      ptgt = ($urandom_range(0, 1) == 1) ? (tgt & ~32'd3) : 32'($urandom_range(0, 255)) * 32'd4;
      step(st, ev, epc, tk, tgt, ptk, ptgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address and PC width.
REQ-002 The block SHALL have parameter BTB_DEPTH, default 16, giving the BTB entry count (power of two, >=2); IDX = log2(BTB_DEPTH).
REQ-003 The block SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded at reset.
REQ-004 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, giving the redirect target on a misaligned taken target.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low; this polarity and synchronicity are fixed.
REQ-007 stall_F  in  1  hold the fetch PC this cycle.
REQ-008 ex_valid  in  1  the EX stage holds a resolved branch or jump this cycle.
REQ-009 ex_pc  in  WIDTH  PC of the resolved instruction.
REQ-010 ex_taken  in  1  actual direction of the resolved instruction.
REQ-011 ex_target  in  WIDTH  actual target of the resolved instruction (PC+imm, or (rs1+imm)&~1).
REQ-012 ex_pred_taken, ex_pred_target  in  1, WIDTH  the prediction made at fetch, as carried down the pipeline.
REQ-013 pc  out  WIDTH  current fetch PC (registered).
REQ-014 pred_taken, pred_target  out  1, WIDTH  combinational BTB prediction for the current pc.
REQ-015 flush  out  1  combinational; high in the cycle a mispredict or misalign is detected.
REQ-016 misalign_err  out  1  combinational; high when ex_valid & ex_taken & ex_target[1:0] != 0.

Function
REQ-017 The BTB SHALL be direct-mapped.
- index = pc[IDX+1:2], tag = pc[WIDTH-1:IDX+2].
- Each entry holds valid, tag, target[WIDTH-1:0], and ctr[1:0].
REQ-018 A BTB hit SHALL be valid & tag match; pred_taken = hit & ctr[1]; pred_target = hit ? entry target : pc+4.
REQ-019 mispredict SHALL be ex_valid & !misalign_err & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
REQ-020 flush SHALL equal mispredict | misalign_err.
REQ-021 next_pc SHALL be selected in this strict priority order:
1. misalign_err -> TRAP_VECTOR.
2. mispredict -> (ex_taken ? ex_target : ex_pc+4).
3. stall_F -> pc (hold).
4. pred_taken -> pred_target.
5. otherwise -> pc+4.
REQ-022 A redirect SHALL override stall_F and SHALL take effect at the next edge, giving 1-cycle redirect latency.
REQ-023 All PC additions SHALL wrap modulo 2^WIDTH; the low two bits of pc SHALL always be zero outside reset.
REQ-024 BTB update SHALL occur on the edge where ex_valid=1 and misalign_err=0, at the entry indexed by ex_pc:
- Taken and hit: write target, ctr = min(ctr+1, 3).
- Taken and miss: write valid=1, tag, target, ctr = 2'b10.
- Not taken and hit: ctr = max(ctr-1, 0); target unchanged.
- Not taken and miss: no change.
REQ-025 BTB updates SHALL proceed regardless of stall_F.
REQ-026 A same-cycle read and update of the same index SHALL return the old contents; the new contents are visible from the next cycle.
REQ-027 A misaligned taken target SHALL leave the BTB unmodified.

Reset
REQ-028 While rst=0:
- pc = RESET_VECTOR, asynchronously.
- All BTB valid bits = 0.
- Therefore pred_taken = 0 and pred_target = RESET_VECTOR+4.
REQ-029 Asserting rst mid-operation SHALL discard any pending redirect.
REQ-030 The first edge after rst deasserts SHALL load next_pc per REQ-021; BTB target and ctr fields need no reset.

Verification
REQ-031 Reset then free-run: rst low, then high for 4 cycles, no ex_valid -> pc = 0, 4, 8, 12, 16; pred_taken = 0 throughout.
REQ-032 Cold taken branch:
- Stimulus: ex_valid, ex_pc=0x8, ex_taken=1, ex_target=0x40, ex_pred_taken=0.
- Response: flush=1; next pc=0x40.
- Later fetch of 0x8: pred_taken=1, pred_target=0x40, ctr=2.
REQ-033 Counter saturation and decay:
- Three more taken resolutions at 0x8 -> ctr stays at 3.
- Then two not-taken resolutions -> ctr=1, and fetch of 0x8 predicts not-taken (pc+4 = 0xC).
REQ-034 Stall versus redirect:
- stall_F=1 for 3 cycles with no redirect -> pc holds its value.
- Mispredict asserted during the stall (ex_taken=0, ex_pc=0x20, ex_pred_taken=1) -> next pc = 0x24 despite the stall.
REQ-035 Misalign: ex_valid, ex_taken=1, ex_target=0x42 -> misalign_err=1, flush=1, next pc=TRAP_VECTOR (0x100), BTB unchanged.
REQ-036 Wrap and aliasing:
- pc = 0xFFFF_FFFC with no prediction -> next pc = 0x0.
- Two branches sharing an index with different tags -> the second overwrites the entry; the first then misses.
